// File: rtl/sub_parser.sv
`default_nettype none
// ============================================================================
// Module   : sub_parser
// Brief    : Per-field header extractor. Latches a 1024-bit header window,
//            then applies one parse action per cycle, copying a 2/4/6-byte
//            field into a typed PHV container. Emits the assembled PHV over
//            a valid/ready handshake after the last action.
// Revision : 1.0 - initial release
// ============================================================================
module sub_parser #(
    parameter int C_PKT_VEC_WIDTH = 6400,
    parameter int C_PARSE_ACT_LEN = 16,
    parameter int C_HDR_WIDTH     = 1024
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic                       hdr_valid,
    input  logic [C_HDR_WIDTH-1:0]     hdr_data,
    input  logic [255:0]               meta_in,
    output logic                       hdr_ready,
    input  logic                       act_valid,
    input  logic [C_PARSE_ACT_LEN-1:0] act_data,
    input  logic                       act_last,
    output logic                       act_ready,
    output logic                       phv_out_valid,
    output logic [C_PKT_VEC_WIDTH-1:0] phv_out,
    output logic                       phv_out_err,
    input  logic                       phv_out_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PARSE = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    localparam logic [1:0] C_TYPE_2B = 2'b01;
    localparam logic [1:0] C_TYPE_4B = 2'b10;
    localparam logic [1:0] C_TYPE_6B = 2'b11;

    localparam logic [12:0] C_BASE_2B = 13'd256;
    localparam logic [12:0] C_BASE_4B = 13'd1280;
    localparam logic [12:0] C_BASE_6B = 13'd3328;

    logic [1:0]                 r_state;
    logic [1:0]                 w_next;
    logic [C_HDR_WIDTH-1:0]     r_hdr;
    logic [C_PKT_VEC_WIDTH-1:0] r_phv;
    logic                       r_err;
    logic                       r_valid;

    logic                       w_hdr_acc;
    logic                       w_act_acc;
    logic [6:0]                 w_off;
    logic [1:0]                 w_type;
    logic [5:0]                 w_idx;
    logic                       w_en;
    logic [7:0]                 w_nbytes;
    logic [7:0]                 w_end;
    logic                       w_overrun;
    logic [C_HDR_WIDTH+47:0]    w_hdr_pad;
    logic [10:0]                w_top;
    logic [47:0]                w_win;
    logic [15:0]                w_f16;
    logic [31:0]                w_f32;
    logic [47:0]                w_f48;
    logic [12:0]                w_base2;
    logic [12:0]                w_base4;
    logic [12:0]                w_base6;

    // Handshake readiness decodes the state; hdr_ready is masked during reset.
    assign hdr_ready = (r_state == S_IDLE) && !areset;
    assign act_ready = (r_state == S_PARSE);
    assign w_hdr_acc = (r_state == S_IDLE) && hdr_valid;
    assign w_act_acc = (r_state == S_PARSE) && act_valid;

    // Action field decode.
    assign w_off  = act_data[15:9];
    assign w_type = act_data[8:7];
    assign w_idx  = act_data[6:1];
    assign w_en   = act_data[0];

    // Field length in bytes and window overrun test (offset + N > 128).
    always_comb begin
        w_nbytes = 8'd0;
        case (w_type)
            C_TYPE_2B: w_nbytes = 8'd2;
            C_TYPE_4B: w_nbytes = 8'd4;
            C_TYPE_6B: w_nbytes = 8'd6;
            default:   w_nbytes = 8'd0;
        endcase
    end
    assign w_end     = {1'b0, w_off} + w_nbytes;
    assign w_overrun = (w_end > 8'd128);

    // Zero-padding below the window keeps the 48-bit grab in range for any
    // offset; overrunning fields are forced to zero afterwards anyway.
    assign w_hdr_pad = {r_hdr, 48'd0};
    assign w_top     = 11'd1071 - {1'b0, w_off, 3'b000};
    assign w_win     = w_hdr_pad[w_top -: 48];

    assign w_f16 = w_overrun ? 16'd0 : w_win[47:32];
    assign w_f32 = w_overrun ? 32'd0 : w_win[47:16];
    assign w_f48 = w_overrun ? 48'd0 : w_win;

    // Container bit offsets inside the PHV.
    assign w_base2 = C_BASE_2B + {3'b000, w_idx, 4'b0000};
    assign w_base4 = C_BASE_4B + {2'b00, w_idx, 5'b00000};
    assign w_base6 = C_BASE_6B + {2'b00, w_idx, 5'b00000} + {3'b000, w_idx, 4'b0000};

    // FSM state register.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (hdr_valid)            w_next = S_PARSE;
            S_PARSE: if (act_valid && act_last) w_next = S_OUT;
            S_OUT:   if (phv_out_ready)        w_next = S_IDLE;
            default:                           w_next = S_IDLE;
        endcase
    end

    // Header latch, container writes, sticky error and output-valid tracking.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_hdr   <= '0;
            r_phv   <= '0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            if (w_hdr_acc) begin
                r_hdr <= hdr_data;
                r_phv <= {{(C_PKT_VEC_WIDTH-256){1'b0}}, meta_in};
                r_err <= 1'b0;
            end
            if (w_act_acc) begin
                if (w_en && (w_type != 2'b00)) begin
                    case (w_type)
                        C_TYPE_2B: r_phv[w_base2 +: 16] <= w_f16;
                        C_TYPE_4B: r_phv[w_base4 +: 32] <= w_f32;
                        default:   r_phv[w_base6 +: 48] <= w_f48;
                    endcase
                    if (w_overrun) begin
                        r_err <= 1'b1;
                    end
                end
                if (act_last) begin
                    r_valid <= 1'b1;
                end
            end
            if ((r_state == S_OUT) && phv_out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign phv_out_valid = r_valid;
    assign phv_out       = r_phv;
    assign phv_out_err   = r_err;

endmodule
`default_nettype wire

// File: doc/sub_parser.md
# sub_parser

Per-field header extractor that builds a packet header vector (PHV) for the match-action pipeline. It latches one 1024-bit header window and then executes a stream of per-field parse actions, one per cycle, each copying a 2-, 4- or 6-byte field from a byte offset into a typed PHV container. When the last action completes, it emits the full PHV through a valid/ready handshake. It sits in front of the stage pipeline and is the inverse of the deparser's per-container sub-deparser.

## Interface
- C_PKT_VEC_WIDTH, (6+4+2)*64*8+256 (=6400): PHV width. Layout: [255:0] metadata; 2B containers k=0..63 at 256+16k; 4B containers at 1280+32k; 6B containers at 3328+48k.
- C_PARSE_ACT_LEN, 16: parse action width. Fields: [15:9] byte offset (0..127); [8:7] type (01=2B, 10=4B, 11=6B, 00=none); [6:1] container index; [0] enable.
- C_HDR_WIDTH, 1024: header window width; byte b is hdr_data[C_HDR_WIDTH-1-8b -: 8].
- clk  in  1  sole clock; all logic is rising-edge.
- areset  in  1  reset; asynchronous and active-high.
- hdr_valid  in  1  header window and metadata are offered.
- hdr_data  in  C_HDR_WIDTH  header bytes, byte 0 at the MSBs.
- meta_in  in  256  metadata copied to PHV[255:0].
- hdr_ready  out  1  block is in IDLE and can accept a header.
- act_valid  in  1  parse action offered.
- act_data  in  C_PARSE_ACT_LEN  parse action.
- act_last  in  1  marks the final action of this packet.
- act_ready  out  1  block is in PARSE.
- phv_out_valid  out  1  assembled PHV is available.
- phv_out  out  C_PKT_VEC_WIDTH  assembled PHV.
- phv_out_err  out  1  at least one action of this packet overran the window.
- phv_out_ready  in  1  downstream accepts the PHV.

## Operation
- FSM states are IDLE, PARSE and OUT. Reset state is IDLE.
- IDLE:
  - hdr_ready = 1 (forced to 0 while areset is high).
  - On hdr_valid: latch hdr_data; set PHV[255:0] = meta_in; clear all containers to 0; clear the err flag; go to PARSE.
- PARSE:
  - act_ready = 1. Each act_valid cycle consumes exactly one action.
  - If act_data[0]=1 and type≠00, container[type][index] is written with N = 2, 4 or 6 bytes starting at the offset. The first byte lands at the container MSBs (big-endian).
  - Overrun: if offset+N > 128, write 0 to the target container and set err (sticky until the next header).
  - If enable=0 or type=00, the action is consumed with no write.
  - Writes to the same container within one packet: the later write wins.
  - If act_last is set on an accepted action, that action's write is applied, then go to OUT.
- OUT:
  - phv_out_valid = 1. phv_out and phv_out_err are held stable.
  - On phv_out_ready: return to IDLE.
- Headers are never accepted outside IDLE. Actions are never accepted outside PARSE; upstream holds them.
- A packet's action list may be a single action with act_last=1.

## Timing
- All outputs come from registers, except hdr_ready and act_ready, which decode the FSM state.
- Reset values:
  - phv_out_valid = 0, phv_out = 0, phv_out_err = 0, act_ready = 0.
  - hdr_ready = 0 while reset is asserted and 1 in the first cycle after release.
- Header handshake at edge T: PARSE from T+1, so act_ready is high in cycle T+1.
- An action accepted at edge E updates its container at E.
- act_last accepted at edge E: phv_out_valid is high in cycle E+1.
- Minimum packet time is 3 cycles (header, 1 action, output with ready=1), so the block sustains one packet per N_actions+2 cycles.
- phv_out_valid falls in the cycle after the edge where phv_out_ready is sampled high. hdr_ready rises in that same cycle.
- Asserting areset in any state returns the FSM to IDLE immediately and drops phv_out_valid. The partial PHV is discarded with no output.

## Test plan
- Basic 2B field:
  - Stimulus: header bytes 12,13 = 0x08,0x00; action offset=12, type=01, idx=3, en=1, last=1; meta_in=256'hA5.
  - Required: PHV[256+48 +: 16]=16'h0800, PHV[255:0]=A5, all other containers 0, err=0, valid exactly 1 cycle after the action.
- Mixed widths:
  - Stimulus: 6B at offset 0 → idx 0, 4B at offset 26 → idx 5, 2B at offset 23 → idx 63, last on the third action.
  - Required: each container holds its header bytes MSB-first; the PHV appears 3 cycles after the first action.
- Overrun and disabled:
  - Stimulus: 4B at offset 126 → idx 1; an action with en=0 targeting 6B idx 2.
  - Required: 4B idx 1 = 0, 6B idx 2 = 0, phv_out_err = 1. The next packet with legal actions shows err = 0.
- Backpressure:
  - Stimulus: hold phv_out_ready=0 for 10 cycles; drive hdr_valid and act_valid throughout.
  - Required: phv_out stable; hdr_ready = 0 and act_ready = 0 throughout; the next header is accepted in the cycle after ready.
- Overwrite and reuse:
  - Stimulus: two writes to 2B idx 7 (offsets 0 then 2), then a second packet with no write to idx 7.
  - Required: first PHV idx 7 = bytes 2,3; second PHV idx 7 = 0.
- Reset in PARSE:
  - Stimulus: assert areset after 2 of 4 actions.
  - Required: phv_out_valid never rises, and hdr_ready = 1 in the first cycle after release.
